// File: rtl/if_insn_resp.sv
// Instruction-memory responder: returns ROM[ReqAddr] after WAIT_CYCLES wait states, with Busy stalling IF meanwhile.
// Optional macro IF_LAST_HIT_EN: re-requesting the last fetched word from IDLE completes with zero wait.
`ifndef ISA_NOP
`define ISA_NOP 32'h0000_0000
`endif

module if_insn_resp #(
   parameter int ADDR_W      = 30,
   parameter int DATA_W      = 32,
   parameter int IDX_W       = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset_,
   input  logic              ReqEn,
   input  logic [ADDR_W-1:0] ReqAddr,
   input  logic              Flush,
   input  logic              WrEn,
   input  logic [IDX_W-1:0]  WrAddr,
   input  logic [DATA_W-1:0] WrData,
   output logic [DATA_W-1:0] Insn,
   output logic              InsnValid,
   output logic [ADDR_W-1:0] InsnAddr,
   output logic              Busy
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_READY = 2'd2} state_t;

   localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

   state_t            r_state;
   logic [3:0]        r_cnt;
   logic [ADDR_W-1:0] r_addr_q;
   logic [DATA_W-1:0] r_insn;
   logic              r_insn_valid;
   logic [DATA_W-1:0] r_rom [0:(1<<IDX_W)-1];

   logic              w_addr_match;
   logic              w_hit;
   logic              w_busy;

   assign w_addr_match = (ReqAddr == r_addr_q);

   // Program load port is independent of reset so the ROM can be filled while the core is held.
   always_ff @(posedge clk) begin
      if (WrEn)
         r_rom[WrAddr] <= WrData;
   end

`ifdef IF_LAST_HIT_EN
   logic r_last_valid;

   assign w_hit = (r_state == S_IDLE) & ReqEn & ~Flush & r_last_valid & w_addr_match;

   // A write to the held index must win over the READY entry that happens on the same edge.
   always_ff @(posedge clk) begin
      if (reset_ || Flush || (WrEn && (WrAddr == r_addr_q[IDX_W-1:0])))
         r_last_valid <= 1'b0;
      else if ((r_state == S_ACCESS) && (r_cnt == 4'd0))
         r_last_valid <= 1'b1;
      else if ((r_state == S_READY) && ReqEn && !w_addr_match)
         r_last_valid <= 1'b0;
      else if ((r_state == S_IDLE) && ReqEn && !w_hit)
         r_last_valid <= 1'b0;
   end
`else
   assign w_hit = 1'b0;
`endif

   always_comb begin
      w_busy = 1'b0;
      case (r_state)
         S_IDLE:   w_busy = ReqEn & ~Flush & ~w_hit;
         S_ACCESS: w_busy = ~Flush;
         S_READY:  w_busy = ReqEn & ~Flush & ~w_addr_match;
         default:  w_busy = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_) begin
         r_state      <= S_IDLE;
         r_cnt        <= 4'd0;
         r_addr_q     <= '0;
         r_insn       <= DATA_W'(`ISA_NOP);
         r_insn_valid <= 1'b0;
      end else if (Flush) begin
         r_state      <= S_IDLE;
         r_insn_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (ReqEn && !w_hit) begin
                  r_addr_q <= ReqAddr;
                  r_cnt    <= LP_WAIT;
                  r_state  <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (r_cnt == 4'd0) begin
                  r_insn       <= r_rom[r_addr_q[IDX_W-1:0]];
                  r_insn_valid <= 1'b1;
                  r_state      <= S_READY;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_READY: begin
               if (ReqEn && w_addr_match) begin
                  r_insn_valid <= 1'b0;
                  r_state      <= S_IDLE;
               end else if (ReqEn) begin
                  r_addr_q     <= ReqAddr;
                  r_cnt        <= LP_WAIT;
                  r_insn_valid <= 1'b0;
                  r_state      <= S_ACCESS;
               end
            end
            default: begin
               r_insn_valid <= 1'b0;
               r_state      <= S_IDLE;
            end
         endcase
      end
   end

   assign Insn      = r_insn;
   assign InsnValid = r_insn_valid | w_hit;
   assign InsnAddr  = r_addr_q;
   assign Busy      = w_busy;

endmodule

// File: doc/if_insn_resp.md
Name: if_insn_resp

Overview:
- Instruction-memory responder: the memory end of the fetch interface consumed by the IF pipeline register.
- Accepts a fetch address and enable from the IF stage and returns the instruction word after a programmable number of wait states.
- Raises Busy, which the pipeline controller ORs into the IF Stall.
- Holds a synchronous-write program ROM/RAM loaded through a side write port.

Parameters:
- ADDR_W, 30, width of the word address (matches `WORD_ADDR_BUS`).
- DATA_W, 32, instruction width (matches `WORD_DATA_BUS`).
- IDX_W, 10, ROM index width; depth = 2**IDX_W words.
- WAIT_CYCLES, 2, extra access cycles; range 0..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_  in  1  synchronous, active-high reset (high = reset).
- ReqEn  in  1  fetch request valid.
- ReqAddr  in  ADDR_W  fetch word address.
- Flush  in  1  abort current fetch (pipeline redirect).
- WrEn  in  1  program-load write enable.
- WrAddr  in  IDX_W  write index.
- WrData  in  DATA_W  write data.
- Insn  out  DATA_W  registered instruction word.
- InsnValid  out  1  Insn is valid for AddrQ (state READY).
- InsnAddr  out  ADDR_W  address Insn belongs to (AddrQ).
- Busy  out  1  combinational; fetch not satisfiable this cycle.

Behaviour:
- Reset (synchronous): state=IDLE, Insn=`ISA_NOP`, InsnValid=0, InsnAddr=0, Cnt=0. Applies mid-access; the in-flight fetch is discarded. ROM contents are not cleared.
- ROM index = ReqAddr[IDX_W-1:0]. Upper address bits are ignored, so the ROM aliases across the address space.
- IDLE:
  - Busy = ReqEn & ~Flush.
  - If ReqEn & ~Flush: AddrQ<=ReqAddr, Cnt<=WAIT_CYCLES, go to ACCESS.
- ACCESS:
  - Busy = ~Flush.
  - If Cnt==0: Insn<=ROM[AddrQ idx], go to READY. Otherwise Cnt<=Cnt-1.
- READY:
  - InsnValid=1.
  - Busy = ReqEn & ~Flush & (ReqAddr!=AddrQ).
  - Address match with ReqEn: word consumed this cycle, go to IDLE.
  - Address mismatch (branch redirect): AddrQ<=ReqAddr, Cnt<=WAIT_CYCLES, go to ACCESS. The stale word is dropped.
  - ~ReqEn: hold READY, Insn stable.
- Flush, any state: Busy=0 that cycle and next state=IDLE. Flush has priority over ReqEn, so the IF stage can load NewPC without being stalled.
- Latency, fresh fetch:
  - Busy is high for WAIT_CYCLES+2 consecutive cycles.
  - The word is consumed in cycle WAIT_CYCLES+3 counted from the first request cycle.
  - WAIT_CYCLES=0 gives 2 busy cycles.
- Write port: ROM[WrAddr]<=WrData on any edge with WrEn, in any state, including during reset.
- Write and final-ACCESS read to the same index in one cycle: the read returns the old data (read-before-write). The registered Insn is never updated by a write.
- Cnt is 4 bits and only counts down; it never wraps.

Optional Feature:
- Macro: IF_LAST_HIT_EN.
- When defined: keep LastValid, set when entering READY. In IDLE, if ReqEn & ~Flush & LastValid & ReqAddr==AddrQ, then Busy=0 and state stays IDLE, reusing Insn with zero wait.
- LastValid is cleared by reset, by Flush, and by WrEn to the AddrQ index.
- When undefined: every fetch takes the full latency. The LastValid logic is absent.

Test Plan:
- Load ROM[5]=32'h1234_5678, WAIT_CYCLES=2, hold ReqEn=1, ReqAddr=5 -> Busy=1 for 4 cycles, then Busy=0 with Insn=32'h1234_5678, InsnValid=1, InsnAddr=5.
- READY holding addr 5, ReqAddr switches to 9 (ROM[9]=32'hAAAA_0009) -> Busy stays 1 for 3 more cycles, then Insn=32'hAAAA_0009.
- Flush=1 in the second ACCESS cycle -> Busy=0 that cycle, state IDLE next; a subsequent fetch of addr 7 takes the full 4 busy cycles.
- reset_=1 asserted mid-ACCESS -> next edge Insn=`ISA_NOP`, InsnValid=0, Busy=ReqEn; ROM[5] still reads 32'h1234_5678 afterwards.
- WrEn to index 5 with 32'hDEAD_BEEF in the cycle the read completes -> Insn=32'h1234_5678; a refetch returns 32'hDEAD_BEEF.
- IF_LAST_HIT_EN defined: fetch 5, consume, re-request 5 -> Busy=0 immediately. After WrEn to index 5, re-request 5 -> full 4-cycle latency.
